// File: rtl/pc_fetch_unit.sv
// Program counter for IF: one-cycle next-PC select (redirect > stall > BR > B > CBZ > +4) with a circular return-address stack.
// currPC updates one edge after the controls; stall freezes PC and RAS, redirect overrides stall.
module pc_fetch_unit #(
    parameter int                 ADDR_W    = 64,
    parameter int                 COND_W    = 19,
    parameter int                 BR_W      = 26,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [COND_W-1:0] condAddr,
    input  logic [BR_W-1:0]   brAddr,
    input  logic              uncondBr,
    input  logic              branch,
    input  logic              flagZero,
    input  logic              branchReg,
    input  logic [ADDR_W-1:0] Rd,
    input  logic              link,
    input  logic              ret,
    output logic [ADDR_W-1:0] currPC,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ras_empty,
    output logic              ras_full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  top_q, top_d, top_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

    logic [ADDR_W-1:0] cond_off, br_off, ras_top;
    logic              advance, pop_req, do_pop, do_push;

    assign currPC    = pc_q;
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_q[top_q];
    assign top_inc   = top_q + PTR_W'(1);

    assign cond_off = {{(ADDR_W-COND_W){condAddr[COND_W-1]}}, condAddr} << 2;
    assign br_off   = {{(ADDR_W-BR_W){brAddr[BR_W-1]}}, brAddr} << 2;

    assign advance = !redirect_valid && !stall;
    assign pop_req = advance && branchReg && ret;
    assign do_pop  = pop_req && !ras_empty;
    assign do_push = advance && link;

    always_comb begin
        pc_d = pc_plus4;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (branchReg) begin
            pc_d = (ret && !ras_empty) ? ras_top : Rd;
        end else if (uncondBr) begin
            pc_d = pc_q + br_off;
        end else if (branch && flagZero) begin
            pc_d = pc_q + cond_off;
        end
    end

    // Combined pop+push rewrites the current top in place; an empty stack gains its first entry there.
    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (do_push && pop_req) begin
            ras_d[top_q] = pc_plus4;
            if (ras_empty) begin
                cnt_d = CNT_W'(1);
            end
        end else if (do_push) begin
            ras_d[top_inc] = pc_plus4;
            top_d          = top_inc;
            if (!ras_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_q <= ras_d;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised next-generation program counter for the 5-stage pipelined ARM CPU.
- Adds over the base PC:
  - pipeline stall (hold);
  - late redirect/flush from EX/MEM;
  - configurable address and offset widths;
  - configurable reset vector;
  - a small circular return-address stack (RAS) that predicts BR targets pushed by BL.
- Sits at the front of IF and drives instruction-memory address and link value.

Parameters:
- ADDR_W, 64, PC/address width.
- COND_W, 19, conditional-branch immediate width.
- BR_W, 26, unconditional-branch immediate width.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hold PC and RAS this cycle.
- redirect_valid  input  1  flush/redirect from later stage.
- redirect_pc  input  ADDR_W  redirect target.
- condAddr  input  COND_W  signed word offset, conditional branch.
- brAddr  input  BR_W  signed word offset, unconditional branch / BL.
- uncondBr  input  1  unconditional branch.
- branch  input  1  conditional branch (CBZ-style).
- flagZero  input  1  zero flag qualifying the conditional branch.
- branchReg  input  1  register-indirect branch (BR).
- Rd  input  ADDR_W  register target for BR.
- link  input  1  instruction is BL; push return address.
- ret  input  1  BR is a return; use RAS prediction.
- currPC  output  ADDR_W  current PC (registered).
- pc_plus4  output  ADDR_W  currPC+4, combinational; link-register value.
- ras_empty  output  1  RAS count == 0.
- ras_full  output  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - currPC=RESET_PC;
  - RAS count=0, top pointer=0;
  - ras_empty=1, ras_full=0.
  - Reset asserted mid-operation discards any pending push/pop/redirect in that cycle.
- Next-PC priority, evaluated each rising edge (first match wins):
  1. rst.
  2. redirect_valid: PC=redirect_pc. Overrides stall. No RAS change.
  3. stall: PC and RAS unchanged. Branch/link/ret inputs are ignored.
  4. branchReg: target = RAS top if (ret && !ras_empty), else Rd.
  5. uncondBr: PC = currPC + (sext(brAddr) << 2).
  6. branch && flagZero: PC = currPC + (sext(condAddr) << 2).
  7. Otherwise: PC = currPC + 4.
- Arithmetic:
  - Offsets are sign-extended to ADDR_W, then shifted left 2.
  - All adds are modulo 2^ADDR_W; no overflow flag. Wrap-around is legal (PC=all-ones-3, +4 -> 0).
  - pc_plus4 is always currPC+4, regardless of control inputs.
- Latency: one cycle from control inputs to currPC. The RAS top read is combinational; RAS updates are registered.
- RAS operations take effect only in cycles that are not reset, not redirect, and not stall:
  - Push (link=1): write pc_plus4 at top+1. Pointer increments mod RAS_DEPTH. Count saturates at RAS_DEPTH.
  - Push when full: overwrites the oldest entry (circular); count stays RAS_DEPTH.
  - Pop (branchReg && ret): pointer decrements mod RAS_DEPTH; count decrements.
  - Pop when empty: target = Rd; pointer and count unchanged.
  - Pop and push in the same cycle (link && branchReg && ret): the target uses the pre-update top, then the top entry is replaced with pc_plus4. Pointer and count are unchanged, except that when empty, count becomes 1.
  - ret without branchReg: ignored. link with any branch type: push still occurs.
- ras_empty and ras_full are registered-state decodes, valid in the cycle after the update.

Test Plan:
- Reset/sequential: assert rst one cycle with RESET_PC=0, then idle 5 cycles -> currPC = 0, 4, 8, 12, 16, 20; pc_plus4 = currPC+4 throughout.
- Conditional/unconditional branches:
  - At currPC=0x20, condAddr=19, branch=1, flagZero=1 -> next currPC=0x6C.
  - Same with flagZero=0 -> 0x24.
  - At 0x100, uncondBr=1, brAddr=26'h3FFFFFE (-2) -> 0xF8.
- Stall vs redirect:
  - stall=1 for 3 cycles at 0x40 -> currPC holds 0x40.
  - stall=1 with redirect_valid=1, redirect_pc=0x200 -> currPC=0x200 next cycle.
  - stall with link=1 -> RAS count unchanged.
- RAS basic:
  - At 0x40, uncondBr=1, link=1, brAddr=0x10 -> currPC=0x80, RAS top=0x44.
  - Later branchReg=1, ret=1, Rd=12 -> currPC=0x44, ras_empty=1.
  - Repeat the ret -> currPC=12.
- RAS overflow (RAS_DEPTH=4): five BLs pushing 0x104, 0x204, 0x304, 0x404, 0x504 -> ras_full=1. Five rets with Rd=0x999 -> targets 0x504, 0x404, 0x304, 0x204, then 0x999.
- Wrap/reset mid-operation:
  - currPC=2^64-4, idle -> currPC=0.
  - After 2 pushes, assert rst together with link=1 -> currPC=RESET_PC, ras_empty=1.
